// File: rtl/mem_bank_stream_reader_if.sv
// Request, memory read port and output stream of the bank stream reader.
// The reader side uses the master modport; memory/consumer models use slave.
interface mem_bank_stream_reader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 64,
  parameter int NUM_BANKS  = 2,
  parameter int BANK_WIDTH = $clog2(NUM_BANKS)
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);

  logic                  start;
  logic [BANK_WIDTH-1:0] start_bank;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [ADDR_WIDTH:0]   length;
  logic                  busy;
  logic                  done;
  logic [BANK_WIDTH-1:0] mem_bank;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_re;
  logic [DATA_WIDTH-1:0] mem_dout;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;

  modport master (
    input  start, start_bank, start_addr, length, mem_dout, m_ready,
    output busy, done, mem_bank, mem_addr, mem_re, m_data, m_valid, m_last
  );

  modport slave (
    output start, start_bank, start_addr, length, mem_dout, m_ready,
    input  busy, done, mem_bank, mem_addr, mem_re, m_data, m_valid, m_last
  );
endinterface

// File: rtl/mem_bank_stream_reader.sv
// Walks a contiguous address run in one memory bank and streams the words out,
// hiding read latency behind a credit-limited output FIFO.
module mem_bank_stream_reader #(
  parameter int DATA_WIDTH   = 16,
  parameter int DEPTH        = 64,
  parameter int NUM_BANKS    = 2,
  parameter int BANK_WIDTH   = $clog2(NUM_BANKS),
  parameter int OUTPUT_DELAY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input logic                      clk,
  input logic                      reset_n,
  mem_bank_stream_reader_if.master bus
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int LEN_WIDTH  = ADDR_WIDTH + 1;
  localparam int PTR_WIDTH  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_WIDTH  = $clog2(FIFO_DEPTH + OUTPUT_DELAY + 1) + 1;
  localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state, state_d;

  logic [BANK_WIDTH-1:0] bank_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  remaining_q;
  logic                  busy_q, done_q;
  logic                  issue, issue_last, accept_start, zero_start, finish;
  logic                  wr_en, wr_last, rd_en, credit_ok, head_valid;
  logic [CNT_WIDTH-1:0]  inflight, fifo_count;
  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last;
  logic [PTR_WIDTH-1:0]  wr_ptr, rd_ptr;

  function automatic logic [PTR_WIDTH-1:0] ptr_next(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_WIDTH'(1);
  endfunction

  // A read may only be issued if its word is guaranteed a FIFO slot on arrival.
  assign credit_ok  = (inflight + fifo_count) < CNT_WIDTH'(FIFO_DEPTH);
  assign issue_last = (remaining_q == LEN_WIDTH'(1));
  assign head_valid = (fifo_count != '0);
  assign rd_en      = head_valid && bus.m_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d      = state;
    issue        = 1'b0;
    accept_start = 1'b0;
    zero_start   = 1'b0;
    finish       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.length != '0) begin
            accept_start = 1'b1;
            state_d      = ISSUE;
          end else begin
            zero_start = 1'b1;
          end
        end
      end
      ISSUE: begin
        issue = credit_ok;
        if (issue && issue_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (rd_en && fifo_last[rd_ptr]) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bank_q      <= '0;
      addr_q      <= '0;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= zero_start || finish;
      if (accept_start) begin
        bank_q      <= bus.start_bank;
        addr_q      <= bus.start_addr;
        remaining_q <= bus.length;
        busy_q      <= 1'b1;
      end else begin
        if (issue) begin
          addr_q      <= addr_q + ADDR_WIDTH'(1);
          remaining_q <= remaining_q - LEN_WIDTH'(1);
        end
        if (finish) busy_q <= 1'b0;
      end
    end
  end

  // Valid/last tokens travel alongside the memory latency so the returning
  // word is captured exactly when mem_dout carries it.
  generate
    if (OUTPUT_DELAY == 0) begin : g_no_pipe
      assign wr_en    = issue;
      assign wr_last  = issue_last;
      assign inflight = '0;
    end else begin : g_pipe
      logic [OUTPUT_DELAY-1:0] pipe_valid, pipe_last;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          pipe_valid <= '0;
          pipe_last  <= '0;
        end else begin
          pipe_valid[0] <= issue;
          pipe_last[0]  <= issue && issue_last;
          for (int i = 1; i < OUTPUT_DELAY; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            pipe_last[i]  <= pipe_last[i-1];
          end
        end
      end

      always_comb begin
        inflight = '0;
        for (int i = 0; i < OUTPUT_DELAY; i++) inflight = inflight + CNT_WIDTH'(pipe_valid[i]);
      end

      assign wr_en   = pipe_valid[OUTPUT_DELAY-1];
      assign wr_last = pipe_last[OUTPUT_DELAY-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (wr_en) fifo_data[wr_ptr] <= bus.mem_dout;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      fifo_last  <= '0;
    end else begin
      if (wr_en) begin
        fifo_last[wr_ptr] <= wr_last;
        wr_ptr            <= ptr_next(wr_ptr);
      end
      if (rd_en) rd_ptr <= ptr_next(rd_ptr);
      case ({wr_en, rd_en})
        2'b10:   fifo_count <= fifo_count + CNT_WIDTH'(1);
        2'b01:   fifo_count <= fifo_count - CNT_WIDTH'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.mem_bank = bank_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_re   = issue;
  assign bus.m_valid  = head_valid;
  assign bus.m_last   = head_valid && fifo_last[rd_ptr];
  assign bus.m_data   = head_valid ? fifo_data[rd_ptr] : '0;
endmodule

// File: tb/tb_mem_bank_stream_reader.sv
// Directed bench for mem_bank_stream_reader: main instance at latency 1 plus
// latency 0 and 2 instances for the latency sweep. Memory word = bank*0x1000 + addr.
module tb_mem_bank_stream_reader;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mem_bank_stream_reader_if #(.DATA_WIDTH(16), .DEPTH(64), .NUM_BANKS(2)) bus0 ();
  mem_bank_stream_reader_if #(.DATA_WIDTH(16), .DEPTH(64), .NUM_BANKS(2)) bus1 ();
  mem_bank_stream_reader_if #(.DATA_WIDTH(16), .DEPTH(64), .NUM_BANKS(2)) bus2 ();

  mem_bank_stream_reader #(.DATA_WIDTH(16), .DEPTH(64), .NUM_BANKS(2), .OUTPUT_DELAY(0), .FIFO_DEPTH(4))
    u_dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));
  mem_bank_stream_reader #(.DATA_WIDTH(16), .DEPTH(64), .NUM_BANKS(2), .OUTPUT_DELAY(1), .FIFO_DEPTH(4))
    u_dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));
  mem_bank_stream_reader #(.DATA_WIDTH(16), .DEPTH(64), .NUM_BANKS(2), .OUTPUT_DELAY(2), .FIFO_DEPTH(4))
    u_dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2));

  function automatic logic [15:0] mem_word(input logic bank, input logic [5:0] addr);
    return {3'b000, bank, 6'b000000, addr};
  endfunction

  // Memory models with read latency 0, 1 and 2.
  logic [15:0] rd1_q, rd2_a, rd2_b;
  always @(posedge clk) begin
    rd1_q <= mem_word(bus1.mem_bank, bus1.mem_addr);
    rd2_a <= mem_word(bus2.mem_bank, bus2.mem_addr);
    rd2_b <= rd2_a;
  end
  assign bus0.mem_dout = mem_word(bus0.mem_bank, bus0.mem_addr);
  assign bus1.mem_dout = rd1_q;
  assign bus2.mem_dout = rd2_b;

  logic [15:0] words0[$], words1[$], words2[$];
  logic        lasts1[$];
  logic [5:0]  addr_log[$];
  logic        bank_log[$];
  int re_cnt, acc_cnt, done_cnt, max_out, stable_err, s_cyc, v0, v1, v2;
  logic        prev_stall;
  logic [15:0] prev_data;
  logic        prev_last;

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus1.start && !bus1.busy) s_cyc = cyc;
      if (bus1.mem_re) begin
        re_cnt++;
        addr_log.push_back(bus1.mem_addr);
        bank_log.push_back(bus1.mem_bank);
      end
      if (bus0.m_valid && v0 < 0) v0 = cyc;
      if (bus1.m_valid && v1 < 0) v1 = cyc;
      if (bus2.m_valid && v2 < 0) v2 = cyc;
      if (bus1.m_valid && bus1.m_ready) begin
        words1.push_back(bus1.m_data);
        lasts1.push_back(bus1.m_last);
        acc_cnt++;
      end
      if (bus0.m_valid && bus0.m_ready) words0.push_back(bus0.m_data);
      if (bus2.m_valid && bus2.m_ready) words2.push_back(bus2.m_data);
      if (bus1.done) done_cnt++;
      if (re_cnt - acc_cnt > max_out) max_out = re_cnt - acc_cnt;
      if (prev_stall && (!bus1.m_valid || bus1.m_data !== prev_data || bus1.m_last !== prev_last))
        stable_err++;
      prev_stall = bus1.m_valid && !bus1.m_ready;
      prev_data  = bus1.m_data;
      prev_last  = bus1.m_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  function automatic logic [127:0] pack_words(input logic [15:0] q[$]);
    logic [127:0] r = '0;
    foreach (q[i]) r = {r[111:0], q[i]};
    return r;
  endfunction

  function automatic logic [127:0] pack_bits(input logic q[$]);
    logic [127:0] r = '0;
    foreach (q[i]) r = {r[126:0], q[i]};
    return r;
  endfunction

  function automatic logic [127:0] pack_addrs(input logic [5:0] q[$]);
    logic [127:0] r = '0;
    foreach (q[i]) r = {r[121:0], q[i]};
    return r;
  endfunction

  function automatic logic [127:0] outs1();
    return 128'({bus1.busy, bus1.done, bus1.mem_re, bus1.m_valid, bus1.m_last,
                 bus1.mem_bank, bus1.mem_addr, bus1.m_data});
  endfunction

  task automatic check_output(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic clear_logs();
    words0.delete(); words1.delete(); words2.delete(); lasts1.delete();
    addr_log.delete(); bank_log.delete();
    re_cnt = 0; acc_cnt = 0; done_cnt = 0; max_out = 0; stable_err = 0;
    s_cyc = -1; v0 = -1; v1 = -1; v2 = -1;
  endtask

  task automatic apply_start(input logic bank, input logic [5:0] addr, input logic [6:0] len, input bit all);
    @(posedge clk); #1;
    bus1.start = 1'b1; bus1.start_bank = bank; bus1.start_addr = addr; bus1.length = len;
    if (all) begin
      bus0.start = 1'b1; bus0.start_bank = bank; bus0.start_addr = addr; bus0.length = len;
      bus2.start = 1'b1; bus2.start_bank = bank; bus2.start_addr = addr; bus2.length = len;
    end
    @(posedge clk); #1;
    bus0.start = 1'b0; bus1.start = 1'b0; bus2.start = 1'b0;
  endtask

  task automatic run_until_done(input int bound, input bit backpressure);
    for (int i = 0; i < bound && done_cnt == 0; i++) begin
      @(posedge clk); #1;
      if (backpressure) bus1.m_ready = (i % 4 == 0) || (i % 4 == 3);
    end
    bus1.m_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus0.start = 0; bus0.start_bank = 0; bus0.start_addr = 0; bus0.length = 0; bus0.m_ready = 1;
    bus1.start = 0; bus1.start_bank = 0; bus1.start_addr = 0; bus1.length = 0; bus1.m_ready = 1;
    bus2.start = 0; bus2.start_bank = 0; bus2.start_addr = 0; bus2.length = 0; bus2.m_ready = 1;
    clear_logs();
    prev_stall = 0; prev_data = 0; prev_last = 0;

    repeat (2) @(posedge clk);
    #1;
    check_output("reset_outputs", outs1(), 128'(0));
    reset_n = 1'b1;

    $display("[TB] basic read bank1 addr2 len4");
    clear_logs();
    apply_start(1'b1, 6'd2, 7'd4, 1'b0);
    check_output("basic_busy", 128'(bus1.busy), 128'(1));
    run_until_done(40, 1'b0);
    check_output("basic_words", pack_words(words1), 128'h1002_1003_1004_1005);
    check_output("basic_count", 128'(words1.size()), 128'(4));
    check_output("basic_last", pack_bits(lasts1), 128'b0001);
    check_output("basic_re_cnt", 128'(re_cnt), 128'(4));
    check_output("basic_done_cnt", 128'(done_cnt), 128'(1));
    check_output("basic_latency", 128'(v1 - s_cyc), 128'(3));
    check_output("basic_idle", 128'(bus1.busy), 128'(0));

    $display("[TB] wrap bank1 addr62 len4");
    clear_logs();
    apply_start(1'b1, 6'd62, 7'd4, 1'b0);
    run_until_done(40, 1'b0);
    check_output("wrap_addrs", pack_addrs(addr_log), 128'({6'd62, 6'd63, 6'd0, 6'd1}));
    check_output("wrap_banks", pack_bits(bank_log), 128'b1111);
    check_output("wrap_words", pack_words(words1), 128'h103E_103F_1000_1001);

    $display("[TB] backpressure bank1 addr10 len8");
    clear_logs();
    apply_start(1'b1, 6'd10, 7'd8, 1'b0);
    run_until_done(120, 1'b1);
    check_output("bp_words", pack_words(words1), 128'h100A_100B_100C_100D_100E_100F_1010_1011);
    check_output("bp_count", 128'(words1.size()), 128'(8));
    check_output("bp_last", pack_bits(lasts1), 128'b0000_0001);
    check_output("bp_outstanding_le4", 128'(max_out <= 4), 128'(1));
    check_output("bp_stable", 128'(stable_err), 128'(0));
    check_output("bp_done_cnt", 128'(done_cnt), 128'(1));

    $display("[TB] zero length start");
    clear_logs();
    apply_start(1'b0, 6'd5, 7'd0, 1'b0);
    check_output("zero_done_pulse", 128'({bus1.done, bus1.busy}), 128'(2'b10));
    repeat (4) @(posedge clk);
    #1;
    check_output("zero_re_cnt", 128'(re_cnt), 128'(0));
    check_output("zero_done_cnt", 128'(done_cnt), 128'(1));
    check_output("zero_busy", 128'(bus1.busy), 128'(0));

    $display("[TB] start while busy is ignored");
    clear_logs();
    apply_start(1'b1, 6'd20, 7'd4, 1'b0);
    bus1.start = 1'b1; bus1.start_bank = 1'b0; bus1.start_addr = 6'd0; bus1.length = 7'd2;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    run_until_done(40, 1'b0);
    check_output("busy_start_words", pack_words(words1), 128'h1014_1015_1016_1017);
    check_output("busy_start_re_cnt", 128'(re_cnt), 128'(4));
    check_output("busy_start_done_cnt", 128'(done_cnt), 128'(1));
    check_output("busy_start_addrs", pack_addrs(addr_log), 128'({6'd20, 6'd21, 6'd22, 6'd23}));

    $display("[TB] latency sweep 0/1/2");
    clear_logs();
    apply_start(1'b1, 6'd2, 7'd4, 1'b1);
    run_until_done(40, 1'b0);
    check_output("sweep_lat0", 128'(v0 - s_cyc), 128'(2));
    check_output("sweep_lat1", 128'(v1 - s_cyc), 128'(3));
    check_output("sweep_lat2", 128'(v2 - s_cyc), 128'(4));
    check_output("sweep_words0", pack_words(words0), 128'h1002_1003_1004_1005);
    check_output("sweep_words1", pack_words(words1), 128'h1002_1003_1004_1005);
    check_output("sweep_words2", pack_words(words2), 128'h1002_1003_1004_1005);

    $display("[TB] reset mid-transfer");
    clear_logs();
    apply_start(1'b1, 6'd30, 7'd8, 1'b0);
    for (int i = 0; i < 60 && acc_cnt < 3; i++) begin
      @(posedge clk); #1;
    end
    check_output("mid_words_before_reset", pack_words(words1), 128'h101E_101F_1020);
    reset_n = 1'b0;
    #1;
    check_output("mid_reset_outputs", outs1(), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    check_output("mid_reset_hold", outs1(), 128'(0));
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_output("mid_no_done", 128'(done_cnt), 128'(0));
    check_output("mid_idle_after", 128'({bus1.busy, bus1.m_valid, bus1.mem_re}), 128'(0));
    clear_logs();
    apply_start(1'b0, 6'd40, 7'd3, 1'b0);
    run_until_done(40, 1'b0);
    check_output("post_reset_words", pack_words(words1), 128'h0028_0029_002A);
    check_output("post_reset_done_cnt", 128'(done_cnt), 128'(1));
    check_output("post_reset_re_cnt", 128'(re_cnt), 128'(3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_bank_stream_reader.md
Name: mem_bank_stream_reader

Overview:
- Read-side sequencer for a multi-bank simple-dual-port memory.
- On a start pulse it walks a contiguous run of addresses in one bank, driving the memory read port (bank, addr, read-enable).
- It absorbs the memory read latency and streams the words out on a valid/ready interface with a last flag.
- A credit-limited output FIFO provides backpressure without ever dropping an in-flight read.

Parameters:
- DATA_WIDTH, 16, width of one memory word.
- DEPTH, 64, words per bank; power of two.
- NUM_BANKS, 2, number of banks.
- BANK_WIDTH, $clog2(NUM_BANKS), bank select width.
- OUTPUT_DELAY, 1, memory read latency in cycles (0, 1 or 2); must equal the memory's setting.
- FIFO_DEPTH, 4, output FIFO entries; must be >= OUTPUT_DELAY+1.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only when busy=0
- start_bank  in  BANK_WIDTH  bank to read
- start_addr  in  $clog2(DEPTH)  first address
- length  in  $clog2(DEPTH)+1  words to read, 0..DEPTH
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at transfer completion
- mem_bank  out  BANK_WIDTH  memory read bank
- mem_addr  out  $clog2(DEPTH)  memory read address
- mem_re  out  1  memory read enable; one word per high cycle
- mem_dout  in  DATA_WIDTH  memory read data, valid OUTPUT_DELAY cycles after mem_re
- m_data  out  DATA_WIDTH  stream data
- m_valid  out  1  stream valid
- m_ready  in  1  stream ready
- m_last  out  1  marks the final word of the transfer

Behaviour:
Reset:
- Asynchronous active-low; every output is 0 while reset_n=0.
- FIFO, credit counter, latency pipeline and state are all cleared.

State machine (IDLE, ISSUE, DRAIN):
- IDLE:
  - start=1 with length>0: latch bank, addr and remaining=length; busy=1 next cycle; go to ISSUE.
  - start=1 with length=0: busy stays 0; done pulses the next cycle; no mem_re.
- ISSUE:
  - Assert mem_re in any cycle where inflight + fifo_count < FIFO_DEPTH.
  - On each mem_re: addr increments by 1 modulo DEPTH, wrapping within the same bank; the bank never changes. remaining decrements.
  - When the last read is issued, go to DRAIN.
- DRAIN:
  - When the word flagged last is accepted (m_valid && m_ready && m_last): busy=0 and done=1 that same cycle edge (registered outputs, visible the next cycle); return to IDLE.
- start while busy=1 is ignored with no side effects.

Latency pipeline:
- A valid/last shift register of length OUTPUT_DELAY tracks issued reads.
- When its output is set, mem_dout is written into the FIFO.
- With OUTPUT_DELAY=0, mem_dout is captured in the same cycle as mem_re.
- inflight = number of set stages in the pipeline.
- The credit rule guarantees the FIFO never overflows, so no write is ever lost.

Stream:
- m_valid = FIFO not empty. m_data and m_last come from the FIFO head.
- While m_valid && !m_ready, m_data and m_last hold stable.
- A FIFO write and read in the same cycle are both honoured.
- Throughput: with m_ready held at 1, one word per cycle. First m_valid appears OUTPUT_DELAY+2 cycles after the start cycle (1 cycle to latch, 1 to issue, plus latency, plus the FIFO register).

Boundaries:
- length=DEPTH reads every word of the bank exactly once.
- Reset mid-transfer discards in-flight and buffered words; no done pulse.

Test Plan:
- Basic read: OUTPUT_DELAY=1, bank1 preloaded with word[a]=0x1000+a; start bank=1, addr=2, length=4, m_ready=1 -> m_data 0x1002..0x1005 on 4 consecutive cycles; m_last only on 0x1005; done once; exactly 4 mem_re pulses.
- Wrap: addr=62, length=4, DEPTH=64 -> mem_addr 62, 63, 0, 1; mem_bank constant; data in that order.
- Backpressure: length=8, m_ready toggled 1,0,0,1 repeating -> all 8 words delivered in order with none duplicated; inflight + fifo_count never exceeds 4; data stable while stalled.
- Zero length / busy start: length=0 -> done pulse, no mem_re, busy stays 0. A start pulse during busy (bank=0, length=2) -> ignored; the original transfer completes unchanged.
- Latency sweep: repeat basic read for OUTPUT_DELAY = 0, 1, 2 -> identical data sequence; first m_valid at start+2, +3, +4 cycles.
- Reset mid-transfer: assert reset_n=0 after the 3rd word of 8 -> all outputs 0 immediately; no done. A new start after release reads correctly from a fresh address.
